// File: rtl/asansor_cagri_panel.sv
// Elevator hall-call panel for three floors.
// Raw call buttons are synchronized and debounced. Each accepted press
// latches a pending lamp bit. A two-state FSM presents the nearest pending
// floor as a target, holds it until the car acknowledges arrival, and then
// clears that floor's lamp.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no live request; picks the nearest pending floor when one exists
// SERVE | o_floor is a live target; waits for i_ack
module asansor_cagri_panel #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_call,
  input  logic       i_ack,
  output logic [1:0] o_floor,
  output logic       o_valid,
  output logic [2:0] o_pending,
  output logic [1:0] o_cur
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SERVE = 2'b01;

  // Terminal count: the level flips on the DEB_CYCLES-th consecutive
  // disagreeing sample.
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [2:0] sync_q1;
  logic [2:0] sync_q2;
  logic [7:0] deb_cnt [3];
  logic [2:0] deb_lvl;
  logic [2:0] rise;
  logic [1:0] state;
  logic       hold;
  logic [1:0] sel_floor;
  logic [2:0] clr_mask;

  // Two-flop synchronizer on the raw buttons.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q1 <= 3'b000;
      sync_q2 <= 3'b000;
    end else begin
      sync_q1 <= i_call;
      sync_q2 <= sync_q1;
    end
  end

  // Per-button debounce: count consecutive disagreements, restart on agreement.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      deb_lvl <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_q2[i] != deb_lvl[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb_lvl[i] <= sync_q2[i];
            deb_cnt[i] <= 8'd0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 8'd1;
          end
        end else begin
          deb_cnt[i] <= 8'd0;
        end
      end
    end
  end

  // A press is accepted on the edge where the debounced level goes 0->1.
  always_comb begin
    rise = 3'b000;
    for (int i = 0; i < 3; i++) begin
      rise[i] = sync_q2[i] & ~deb_lvl[i] & (deb_cnt[i] == DEB_LAST);
    end
  end

  // Nearest pending floor to o_cur; a tie between 0 and 2 goes to floor 0.
  always_comb begin
    sel_floor = 2'd0;
    case (o_cur)
      2'd1: begin
        if (o_pending[1])      sel_floor = 2'd1;
        else if (o_pending[0]) sel_floor = 2'd0;
        else                   sel_floor = 2'd2;
      end
      2'd2: begin
        if (o_pending[2])      sel_floor = 2'd2;
        else if (o_pending[1]) sel_floor = 2'd1;
        else                   sel_floor = 2'd0;
      end
      default: begin
        if (o_pending[0])      sel_floor = 2'd0;
        else if (o_pending[1]) sel_floor = 2'd1;
        else                   sel_floor = 2'd2;
      end
    endcase
  end

  // Lamp of the served floor is cleared on the ack edge; this beats a press
  // on that floor landing on the same edge.
  always_comb begin
    clr_mask = 3'b000;
    if (state == SERVE && i_ack) clr_mask = 3'b001 << o_floor;
  end

  // Request FSM, lamp register and served-floor tracking. After an ack the
  // FSM sits in IDLE one extra cycle (hold) before presenting the next target.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      hold      <= 1'b0;
      o_floor   <= 2'd0;
      o_valid   <= 1'b0;
      o_cur     <= 2'd0;
      o_pending <= 3'b000;
    end else begin
      o_pending <= (o_pending | rise) & ~clr_mask;
      case (state)
        IDLE: begin
          if (hold) begin
            hold <= 1'b0;
          end else if (o_pending != 3'b000) begin
            o_floor <= sel_floor;
            o_valid <= 1'b1;
            state   <= SERVE;
          end
        end
        SERVE: begin
          if (i_ack) begin
            o_cur   <= o_floor;
            o_valid <= 1'b0;
            hold    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          hold    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asansor_cagri_panel.sv
// Bench for asansor_cagri_panel: directed scenarios followed by random
// button/ack traffic, all compared each cycle against a behavioural model.
module tb_asansor_cagri_panel;

  localparam int DEB = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [2:0] i_call = 3'b000;
  logic       i_ack = 1'b0;
  logic [1:0] o_floor;
  logic       o_valid;
  logic [2:0] o_pending;
  logic [1:0] o_cur;

  int checks = 0;
  int errors = 0;

  asansor_cagri_panel #(.DEB_CYCLES(DEB)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_call   (i_call),
    .i_ack    (i_ack),
    .o_floor  (o_floor),
    .o_valid  (o_valid),
    .o_pending(o_pending),
    .o_cur    (o_cur)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- behavioural reference model ----------------
  bit       m_s1 [3];
  bit       m_s2 [3];
  bit       m_lvl [3];
  bit       hist [3][$];
  bit [2:0] m_pend;
  bit       m_busy;
  bit       m_hold;
  int       m_target;
  int       m_cur;

  function automatic int nearest(input bit [2:0] p, input int cur);
    int best = -1;
    int bestd = 99;
    for (int f = 0; f < 3; f++) begin
      int d = (f > cur) ? f - cur : cur - f;
      if (p[f] && d < bestd) begin
        best = f;
        bestd = d;
      end
    end
    return best;
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int f = 0; f < 3; f++) begin
        m_s1[f] = 0; m_s2[f] = 0; m_lvl[f] = 0;
        hist[f].delete();
      end
      m_pend = 0; m_busy = 0; m_hold = 0; m_target = 0; m_cur = 0;
    end else begin
      bit [2:0] rise_m;
      bit [2:0] old_pend;
      rise_m = 0;
      for (int f = 0; f < 3; f++) begin
        bit all_diff;
        hist[f].push_back(m_s2[f]);
        if (hist[f].size() > DEB) void'(hist[f].pop_front());
        all_diff = (hist[f].size() == DEB);
        foreach (hist[f][k]) if (hist[f][k] == m_lvl[f]) all_diff = 0;
        if (all_diff) begin
          m_lvl[f] = ~m_lvl[f];
          if (m_lvl[f]) rise_m[f] = 1;
          hist[f].delete();
        end
      end
      for (int f = 0; f < 3; f++) begin
        m_s2[f] = m_s1[f];
        m_s1[f] = i_call[f];
      end
      old_pend = m_pend;
      m_pend = m_pend | rise_m;
      if (m_busy) begin
        if (i_ack) begin
          m_cur = m_target;
          m_pend[m_target] = 0;
          m_busy = 0;
          m_hold = 1;
        end
      end else if (m_hold) begin
        m_hold = 0;
      end else if (old_pend != 0) begin
        m_target = nearest(old_pend, m_cur);
        m_busy = 1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    @(negedge i_clk);
    chk("valid",   int'(o_valid),   int'(m_busy));
    chk("floor",   int'(o_floor),   m_target);
    chk("pending", int'(o_pending), int'(m_pend));
    chk("cur",     int'(o_cur),     m_cur);
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    int hold_left;
    #2 i_rst = 1'b1;
    @(negedge i_clk);
    chk("rst_valid",   int'(o_valid),   0);
    chk("rst_pending", int'(o_pending), 0);
    chk("rst_cur",     int'(o_cur),     0);
    chk("rst_floor",   int'(o_floor),   0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Single press of floor 1: lamp at edge 6, request at edge 7.
    i_call = 3'b010;
    cycn(5);
    chk("lat_pend_e5", int'(o_pending), 0);
    cyc();
    chk("lat_pend_e6", int'(o_pending), 2);
    chk("lat_valid_e6", int'(o_valid), 0);
    cyc();
    chk("lat_valid_e7", int'(o_valid), 1);
    chk("lat_floor_e7", int'(o_floor), 1);
    cycn(2);
    i_ack = 1'b1;
    cyc();
    i_ack = 1'b0;
    chk("ack_cur", int'(o_cur), 1);
    chk("ack_pend", int'(o_pending), 0);
    chk("ack_valid", int'(o_valid), 0);
    i_call = 3'b000;
    cycn(8);

    // Glitchy floor-2 button never reaches the lamp.
    i_call = 3'b100; cycn(3);
    i_call = 3'b000; cycn(1);
    i_call = 3'b100; cycn(3);
    i_call = 3'b000; cycn(8);
    chk("glitch_pend", int'(o_pending), 0);

    // From floor 1, floors 0 and 2 together: 0 first, then 2 two edges after ack.
    i_call = 3'b101;
    cycn(7);
    chk("tie_valid", int'(o_valid), 1);
    chk("tie_floor", int'(o_floor), 0);
    i_ack = 1'b1; cyc(); i_ack = 1'b0;
    chk("tie_ack_pend", int'(o_pending), 4);
    cyc();
    chk("b2b_valid_e1", int'(o_valid), 0);
    cyc();
    chk("b2b_valid_e2", int'(o_valid), 1);
    chk("b2b_floor", int'(o_floor), 2);

    // While serving floor 2, floor 0 is pressed: no retarget.
    i_call = 3'b000; cycn(6);
    i_call = 3'b001; cycn(7);
    chk("noretarget_floor", int'(o_floor), 2);
    chk("noretarget_pend", int'(o_pending), 5);
    i_ack = 1'b1; cyc(); i_ack = 1'b0;
    cycn(2);
    chk("next_floor", int'(o_floor), 0);
    chk("next_valid", int'(o_valid), 1);
    i_ack = 1'b1; cyc(); i_ack = 1'b0;

    // Served-floor press landing on the ack edge is dropped.
    i_call = 3'b010; cycn(7);
    chk("srv1_floor", int'(o_floor), 1);
    i_call = 3'b000; cycn(6);
    i_call = 3'b010; cycn(5);
    i_ack = 1'b1; cyc(); i_ack = 1'b0;
    chk("coinc_pend", int'(o_pending), 0);
    chk("coinc_valid", int'(o_valid), 0);
    cycn(3);
    chk("coinc_idle", int'(o_valid), 0);

    // Reset in the middle of SERVE drops everything at once.
    i_call = 3'b001; cycn(7);
    chk("pre_rst_valid", int'(o_valid), 1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_pend", int'(o_pending), 0);
    chk("mid_rst_cur", int'(o_cur), 0);
    chk("mid_rst_floor", int'(o_floor), 0);
    cyc();
    i_rst = 1'b0;
    // Button still held through reset release registers again.
    cycn(DEB + 2);
    chk("held_rst_pend", int'(o_pending), 1);

    // Random traffic.
    hold_left = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold_left == 0) begin
        i_call = 3'($urandom_range(0, 7));
        hold_left = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : $urandom_range(4, 12);
      end
      hold_left--;
      i_ack = ($urandom_range(0, 3) == 0);
      i_rst = ($urandom_range(0, 399) == 0);
      cyc();
    end
    i_rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
